// File: rtl/onehot_to_bin_if.sv
// One-hot decoder stream bundle: upstream word, downstream index and error-counter sideband.
// Latency: none, wiring only.
// Backpressure: carries valid/ready in both directions; the slave side is the decoder.
interface onehot_to_bin_if #(
    parameter int BIN_W     = 4,
    parameter int ONE_HOT_W = 16,
    parameter int CNT_W     = 8
);
    logic [ONE_HOT_W-1:0] one_hot_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [BIN_W-1:0]     bin_o;
    logic                 err_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 clr_i;
    logic [CNT_W-1:0]     err_cnt_o;

    // Decoder side.
    modport slave (
        input  one_hot_i, valid_i, ready_i, clr_i,
        output ready_o, bin_o, err_o, valid_o, err_cnt_o
    );

    // Environment side: drives words and downstream ready, observes results.
    modport master (
        output one_hot_i, valid_i, ready_i, clr_i,
        input  ready_o, bin_o, err_o, valid_o, err_cnt_o
    );
endinterface

// File: rtl/onehot_to_bin.sv
// Registered one-hot to binary decoder; flags all-zero / multi-hot words (optional error counter: ONEHOT_ERR_CNT_EN).
// Latency: 1 cycle from accept to valid_o, one word per cycle sustained.
// Backpressure: ready_o = !valid_o || ready_i; output held stable while valid_o && !ready_i.
module onehot_to_bin #(
    parameter int BIN_W     = 4,
    parameter int ONE_HOT_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    onehot_to_bin_if.slave        ifc
);

    generate
        if (ONE_HOT_W > (1 << BIN_W)) begin : g_bad_width
            $error("onehot_to_bin: ONE_HOT_W exceeds 2**BIN_W");
        end
    endgenerate

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic [BIN_W-1:0] bin_q;
    logic             err_q;
    logic [BIN_W-1:0] dec_bin;
    logic             dec_err;
    logic             accept;

    assign ifc.ready_o = (state == EMPTY) || ifc.ready_i;
    assign accept      = ifc.valid_i && ifc.ready_o;

    // Priority scan from the top so the lowest set bit wins; clear-lowest-bit test flags non-one-hot words.
    always_comb begin
        dec_bin = '0;
        for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
            if (ifc.one_hot_i[i]) begin
                dec_bin = BIN_W'(i);
            end
        end
        dec_err = (ifc.one_hot_i == '0) ||
                  ((ifc.one_hot_i & (ifc.one_hot_i - ONE_HOT_W'(1))) != '0);
    end

    // Single-stage EMPTY/FULL register; accept reloads, consume without accept empties and holds data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
            bin_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            state <= FULL;
            bin_q <= dec_bin;
            err_q <= dec_err;
        end else if (state == FULL && ifc.ready_i) begin
            state <= EMPTY;
        end
    end

    assign ifc.valid_o = (state == FULL);
    assign ifc.bin_o   = bin_q;
    assign ifc.err_o   = err_q;

`ifdef ONEHOT_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of errored accepts; a clear on the same edge takes priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (ifc.clr_i) begin
            cnt_q <= '0;
        end else if (accept && dec_err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ifc.err_cnt_o = cnt_q;
`else
    logic unused_clr;

    assign unused_clr    = ifc.clr_i;
    assign ifc.err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_onehot_to_bin.sv
// Randomized and directed check of onehot_to_bin against a behavioural model.
// Latency: model predicts the state after each clock edge.
// Backpressure: random ready_i; upstream holds words until accepted.
module tb_onehot_to_bin;

    localparam int BIN_W     = 4;
    localparam int ONE_HOT_W = 16;
    localparam int CNT_W     = 2;
`ifdef ONEHOT_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    onehot_to_bin_if #(.BIN_W(BIN_W), .ONE_HOT_W(ONE_HOT_W), .CNT_W(CNT_W)) ifc ();

    onehot_to_bin #(.BIN_W(BIN_W), .ONE_HOT_W(ONE_HOT_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ifc   (ifc)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state.
    bit m_vld;
    int m_bin;
    bit m_err;
    int m_cnt;
    bit last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Index of the isolated lowest set bit, by two's-complement arithmetic.
    function automatic int lowest_idx(input logic [ONE_HOT_W-1:0] x);
        logic [ONE_HOT_W-1:0] iso;
        iso = x & (~x + ONE_HOT_W'(1));
        return (x == '0) ? 0 : $clog2(iso);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(ifc.valid_o), 32'(m_vld));
        check({tag, ".bin"},   32'(ifc.bin_o),   32'(m_bin));
        check({tag, ".err"},   32'(ifc.err_o),   32'(m_err));
        check({tag, ".cnt"},   32'(ifc.err_cnt_o), 32'(m_cnt));
    endtask

    // Called at a negedge: drive one cycle of inputs, predict the edge, check at the next negedge.
    task automatic step(input logic [ONE_HOT_W-1:0] oh, input bit v, input bit r, input bit c,
                        input string tag);
        bit acc;
        bit bad;
        ifc.one_hot_i = oh;
        ifc.valid_i   = v;
        ifc.ready_i   = r;
        ifc.clr_i     = c;
        #1;
        check({tag, ".ready"}, 32'(ifc.ready_o), 32'(!m_vld || r));
        acc = v && (!m_vld || r);
        bad = ($countones(oh) != 1);
        if (acc) begin
            m_vld = 1'b1;
            m_bin = lowest_idx(oh);
            m_err = bad;
        end else if (m_vld && r) begin
            m_vld = 1'b0;
        end
        if (CNT_EN) begin
            if (c) m_cnt = 0;
            else if (acc && bad && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
        last_acc = acc;
        @(negedge clk_i);
        check_outputs(tag);
    endtask

    function automatic logic [ONE_HOT_W-1:0] rand_word();
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 60)      return ONE_HOT_W'(1) << $urandom_range(0, ONE_HOT_W - 1);
        else if (sel < 72) return '0;
        else               return ONE_HOT_W'($urandom);
    endfunction

    task automatic random_run(input int cycles, input string tag);
        logic [ONE_HOT_W-1:0] oh;
        bit v;
        oh = rand_word();
        v  = ($urandom_range(0, 9) < 8);
        for (int i = 0; i < cycles; i++) begin
            step(oh, v, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), tag);
            if (!(v && !last_acc)) begin
                oh = rand_word();
                v  = ($urandom_range(0, 9) < 8);
            end
        end
    endtask

    initial begin
        ifc.one_hot_i = '0;
        ifc.valid_i   = 1'b0;
        ifc.ready_i   = 1'b0;
        ifc.clr_i     = 1'b0;
        m_vld = 1'b0; m_bin = 0; m_err = 1'b0; m_cnt = 0;
        last_acc = 1'b0;

        repeat (2) @(negedge clk_i);
        check_outputs("reset");
        rst_i = 1'b0;

        // Plain one-hot word.
        step(16'h0020, 1, 1, 0, "oh5");
        // Zero word, then multi-hot reporting its lowest bit.
        step(16'h0000, 1, 1, 0, "zero");
        step(16'h8100, 1, 1, 0, "multi");
        // Backpressure: hold index 2 while 11 waits, then pass-through accept.
        step(16'h0004, 1, 1, 0, "bp_load");
        repeat (3) step(16'h0800, 1, 0, 0, "bp_hold");
        step(16'h0800, 1, 1, 0, "bp_pass");
        step(16'h0000, 0, 1, 0, "bp_drain");
        // Saturation then clear winning over an errored accept.
        for (int i = 0; i < 5; i++) step(16'h0003, 1, 1, 0, "sat");
        step(16'h0000, 1, 1, 1, "clr_win");
        // Back-to-back stream of all indices.
        for (int k = 0; k < ONE_HOT_W; k++) step(ONE_HOT_W'(1) << k, 1, 1, 0, "stream");
        step(16'h0000, 0, 1, 0, "stream_end");

        random_run(1500, "rand");

        // Asynchronous reset while a stalled output is pending.
        step(16'h0010, 1, 1, 0, "pre_rst");
        step(16'h0001, 1, 0, 0, "stall");
        step(16'h0000, 0, 0, 0, "stall2");
        #2 rst_i = 1'b1;
        #1;
        m_vld = 1'b0; m_bin = 0; m_err = 1'b0; m_cnt = 0;
        check_outputs("async_rst");
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_outputs("post_rst");
        step(16'h0200, 1, 1, 0, "first_after_rst");

        random_run(500, "rand2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
